// File: rtl/sharpen_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one sharpen pipeline between two
// video sources; forwards the owner's stream and demuxes processed output back.
module sharpen_frame_arbiter #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int TIMEOUT   = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src0_req,
  input  logic       src1_req,
  output logic       src0_gnt,
  output logic       src1_gnt,
  input  logic       src0_vsync,
  input  logic       src0_href,
  input  logic [7:0] src0_gray,
  input  logic       src1_vsync,
  input  logic       src1_href,
  input  logic [7:0] src1_gray,
  output logic       pipe_vsync,
  output logic       pipe_href,
  output logic [7:0] pipe_gray,
  input  logic       pipe_post_vsync,
  input  logic       pipe_post_href,
  input  logic [7:0] pipe_post_gray,
  output logic       dst0_vsync,
  output logic       dst0_href,
  output logic [7:0] dst0_gray,
  output logic       dst1_vsync,
  output logic       dst1_href,
  output logic [7:0] dst1_gray,
  output logic       owner,
  output logic       busy,
  output logic       timeout_pulse,
  output logic       frame_err
);

  localparam int HCW = $clog2(IMG_HDISP + 2);
  localparam int VCW = $clog2(IMG_VDISP + 2);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [HCW-1:0] H_TARGET = HCW'(IMG_HDISP);
  localparam logic [HCW-1:0] H_SAT    = HCW'(IMG_HDISP + 1);
  localparam logic [VCW-1:0] V_TARGET = VCW'(IMG_VDISP);
  localparam logic [VCW-1:0] V_SAT    = VCW'(IMG_VDISP + 1);
  localparam logic [TCW-1:0] T_LAST   = TCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT    = 2'd1,
    S_INFLIGHT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t         state_r, state_n_s;
  logic           owner_r, owner_n_s, prio_r, prio_n_s, timeout_s;
  logic [1:0]     vs_prev_r, hr_prev_r;
  logic           post_vs_prev_r, seen_rise_r, line_bad_r;
  logic [TCW-1:0] tcnt_r;
  logic [HCW-1:0] hcnt_r;
  logic [VCW-1:0] vcnt_r, vcnt_inc_s, vcnt_end_s;
  logic           bad_line_now_s, frame_bad_s;
  logic [1:0]     gnt_r, gnt_n_s;
  logic [9:0]     pipe_r, pipe_n_s, dst0_r, dst0_n_s, dst1_r, dst1_n_s;
  logic           busy_r, busy_n_s, timeout_r, frame_err_r, frame_err_n_s;

  logic       own_req_s, own_vs_s, own_hr_s;
  logic [7:0] own_gray_s;
  logic       vs_rise_s, vs_fall_s, hr_fall_s, post_rise_s, post_fall_s, tmo_s;
  logic       fwd_s, dmx_s, enter_flight_s;

  assign own_req_s   = owner_r ? src1_req   : src0_req;
  assign own_vs_s    = owner_r ? src1_vsync : src0_vsync;
  assign own_hr_s    = owner_r ? src1_href  : src0_href;
  assign own_gray_s  = owner_r ? src1_gray  : src0_gray;
  assign vs_rise_s   = own_vs_s & ~vs_prev_r[owner_r];
  assign vs_fall_s   = ~own_vs_s & vs_prev_r[owner_r];
  assign hr_fall_s   = ~own_hr_s & hr_prev_r[owner_r];
  assign post_rise_s = pipe_post_vsync & ~post_vs_prev_r;
  assign post_fall_s = ~pipe_post_vsync & post_vs_prev_r;
  assign tmo_s       = (tcnt_r == T_LAST);
  assign fwd_s       = (state_r == S_GRANT) || (state_r == S_INFLIGHT);
  assign dmx_s       = (state_r == S_INFLIGHT) || (state_r == S_DRAIN);
  assign enter_flight_s = (state_r == S_GRANT) && (state_n_s == S_INFLIGHT);

  // State register with owner and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      owner_r <= owner_n_s;
      prio_r  <= prio_n_s;
    end
  end

  // Next-state logic; prio_r names the source that wins a tie
  always_comb begin
    state_n_s = state_r;
    owner_n_s = owner_r;
    prio_n_s  = prio_r;
    timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (src0_req && src1_req) begin
          owner_n_s = prio_r;
          state_n_s = S_GRANT;
        end else if (src0_req || src1_req) begin
          owner_n_s = src1_req;
          state_n_s = S_GRANT;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_GRANT: begin
        if (vs_rise_s) begin
          state_n_s = S_INFLIGHT;
        end else if (!own_req_s) begin
          state_n_s = S_IDLE;
        end else if (tmo_s) begin
          state_n_s = S_IDLE;
          timeout_s = 1'b1;
          prio_n_s  = ~owner_r;
        end else begin
          state_n_s = S_GRANT;
        end
      end
      S_INFLIGHT: begin
        if (vs_fall_s) begin
          state_n_s = S_DRAIN;
        end else begin
          state_n_s = S_INFLIGHT;
        end
      end
      S_DRAIN: begin
        if (post_fall_s && seen_rise_r) begin
          state_n_s = S_IDLE;
          prio_n_s  = ~owner_r;
        end else if (tmo_s) begin
          state_n_s = S_IDLE;
          timeout_s = 1'b1;
          prio_n_s  = ~owner_r;
        end else begin
          state_n_s = S_DRAIN;
        end
      end
      default: begin
        state_n_s = S_IDLE;
      end
    endcase
  end

  // Next values of registered outputs; a line ending on the vsync-fall cycle still counts
  always_comb begin
    vcnt_inc_s     = (vcnt_r != V_SAT) ? (vcnt_r + VCW'(1)) : vcnt_r;
    vcnt_end_s     = hr_fall_s ? vcnt_inc_s : vcnt_r;
    bad_line_now_s = hr_fall_s && (hcnt_r != H_TARGET);
    frame_bad_s    = line_bad_r || bad_line_now_s || (vcnt_end_s != V_TARGET);
    gnt_n_s        = {owner_n_s, ~owner_n_s} &
                     {2{(state_n_s == S_GRANT) || (state_n_s == S_INFLIGHT)}};
    pipe_n_s       = fwd_s ? {own_vs_s, own_hr_s, own_gray_s} : 10'd0;
    dst0_n_s       = (dmx_s && !owner_r) ? {pipe_post_vsync, pipe_post_href, pipe_post_gray} : 10'd0;
    dst1_n_s       = (dmx_s && owner_r)  ? {pipe_post_vsync, pipe_post_href, pipe_post_gray} : 10'd0;
    busy_n_s       = (state_n_s != S_IDLE);
    frame_err_n_s  = (state_r == S_INFLIGHT) && vs_fall_s && frame_bad_s;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= 2'b00;
      pipe_r      <= 10'd0;
      dst0_r      <= 10'd0;
      dst1_r      <= 10'd0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      gnt_r       <= gnt_n_s;
      pipe_r      <= pipe_n_s;
      dst0_r      <= dst0_n_s;
      dst1_r      <= dst1_n_s;
      busy_r      <= busy_n_s;
      timeout_r   <= timeout_s;
      frame_err_r <= frame_err_n_s;
    end
  end

  // Wait timer for GRANT and DRAIN, restarted on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r <= '0;
    end else if ((state_n_s != state_r) || !((state_r == S_GRANT) || (state_r == S_DRAIN))) begin
      tcnt_r <= '0;
    end else begin
      tcnt_r <= tcnt_r + TCW'(1);
    end
  end

  // Frame geometry counters and pipeline-return tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r      <= '0;
      vcnt_r      <= '0;
      line_bad_r  <= 1'b0;
      seen_rise_r <= 1'b0;
    end else if (enter_flight_s) begin
      hcnt_r      <= '0;
      vcnt_r      <= '0;
      line_bad_r  <= 1'b0;
      seen_rise_r <= 1'b0;
    end else begin
      if (state_r == S_INFLIGHT) begin
        if (hr_fall_s) begin
          hcnt_r <= '0;
          vcnt_r <= vcnt_inc_s;
        end else if (own_hr_s && (hcnt_r != H_SAT)) begin
          hcnt_r <= hcnt_r + HCW'(1);
        end else begin
          hcnt_r <= hcnt_r;
        end
        line_bad_r <= line_bad_r | bad_line_now_s;
      end else begin
        hcnt_r     <= hcnt_r;
        line_bad_r <= line_bad_r;
      end
      seen_rise_r <= seen_rise_r | (dmx_s && post_rise_s);
    end
  end

  // Edge-detect history of both sources and the pipeline return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r      <= 2'b00;
      hr_prev_r      <= 2'b00;
      post_vs_prev_r <= 1'b0;
    end else begin
      vs_prev_r      <= {src1_vsync, src0_vsync};
      hr_prev_r      <= {src1_href, src0_href};
      post_vs_prev_r <= pipe_post_vsync;
    end
  end

  assign src0_gnt      = gnt_r[0];
  assign src1_gnt      = gnt_r[1];
  assign {pipe_vsync, pipe_href, pipe_gray} = pipe_r;
  assign {dst0_vsync, dst0_href, dst0_gray} = dst0_r;
  assign {dst1_vsync, dst1_href, dst1_gray} = dst1_r;
  assign owner         = owner_r;
  assign busy          = busy_r;
  assign timeout_pulse = timeout_r;
  assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_sharpen_frame_arbiter.sv
// Scoreboard bench for sharpen_frame_arbiter: random pixels, a 20-cycle pipeline
// model and a round-robin reference model drive queued expectations.
module tb_sharpen_frame_arbiter;
  localparam int HD = 8, VD = 4, TO = 64, PD = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic src0_req, src1_req, src0_gnt, src1_gnt;
  logic src0_vsync, src0_href, src1_vsync, src1_href;
  logic [7:0] src0_gray, src1_gray;
  logic pipe_vsync, pipe_href, pipe_post_vsync, pipe_post_href;
  logic [7:0] pipe_gray, pipe_post_gray;
  logic dst0_vsync, dst0_href, dst1_vsync, dst1_href;
  logic [7:0] dst0_gray, dst1_gray;
  logic owner, busy, timeout_pulse, frame_err;

  always #5 clk = ~clk;

  sharpen_frame_arbiter #(.IMG_HDISP(HD), .IMG_VDISP(VD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_req(src0_req), .src1_req(src1_req), .src0_gnt(src0_gnt), .src1_gnt(src1_gnt),
    .src0_vsync(src0_vsync), .src0_href(src0_href), .src0_gray(src0_gray),
    .src1_vsync(src1_vsync), .src1_href(src1_href), .src1_gray(src1_gray),
    .pipe_vsync(pipe_vsync), .pipe_href(pipe_href), .pipe_gray(pipe_gray),
    .pipe_post_vsync(pipe_post_vsync), .pipe_post_href(pipe_post_href), .pipe_post_gray(pipe_post_gray),
    .dst0_vsync(dst0_vsync), .dst0_href(dst0_href), .dst0_gray(dst0_gray),
    .dst1_vsync(dst1_vsync), .dst1_href(dst1_href), .dst1_gray(dst1_gray),
    .owner(owner), .busy(busy), .timeout_pulse(timeout_pulse), .frame_err(frame_err)
  );

  // Shared sharpen pipeline modelled as a pure PD-cycle delay
  logic [9:0] pl [PD];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) pl[i] <= 10'd0;
    end else begin
      pl[0] <= {pipe_vsync, pipe_href, pipe_gray};
      for (int i = 1; i < PD; i++) pl[i] <= pl[i-1];
    end
  end
  assign {pipe_post_vsync, pipe_post_href, pipe_post_gray} = pl[PD-1];

  int checks = 0, fails = 0;
  int err_cnt = 0, tmo_cnt = 0;
  logic [8:0] pipeq[$], dstq[$];
  bit gntq[$];
  bit prio_m;
  logic [1:0] gnt_prev = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: a tie goes to the source that did not finish last
  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) return int'(prio_m);
    else if (r0) return 0;
    else return 1;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or a new grant
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      chk("gnt_onehot", {31'd0, src0_gnt & src1_gnt}, 32'd0);
      if ((src0_gnt && !gnt_prev[0]) || (src1_gnt && !gnt_prev[1])) begin
        if (gntq.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
        else chk("gnt_order", {31'd0, src1_gnt}, {31'd0, gntq.pop_front()});
      end
      if (pipe_href) begin
        if (pipeq.size() == 0) chk("pipe_extra_pixel", 32'd1, 32'd0);
        else begin
          e = pipeq.pop_front();
          chk("pipe_pixel", {24'd0, pipe_gray}, {24'd0, e[7:0]});
          chk("pipe_owner", {31'd0, owner}, {31'd0, e[8]});
        end
      end
      if (dst0_href) begin
        if (dstq.size() == 0) chk("dst0_extra_pixel", 32'd1, 32'd0);
        else begin
          e = dstq.pop_front();
          chk("dst0_source", 32'd0, {31'd0, e[8]});
          chk("dst0_pixel", {24'd0, dst0_gray}, {24'd0, e[7:0]});
        end
      end
      if (dst1_href) begin
        if (dstq.size() == 0) chk("dst1_extra_pixel", 32'd1, 32'd0);
        else begin
          e = dstq.pop_front();
          chk("dst1_source", 32'd1, {31'd0, e[8]});
          chk("dst1_pixel", {24'd0, dst1_gray}, {24'd0, e[7:0]});
        end
      end
      chk("dst_gray_blank", {24'd0, (dst0_href ? 8'd0 : dst0_gray) | (dst1_href ? 8'd0 : dst1_gray)}, 32'd0);
      if (frame_err) err_cnt <= err_cnt + 1;
      if (timeout_pulse) tmo_cnt <= tmo_cnt + 1;
      gnt_prev <= {src1_gnt, src0_gnt};
    end else begin
      gnt_prev <= 2'b00;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {16'd0, src0_gnt, src1_gnt, pipe_vsync, pipe_href, pipe_gray,
                        owner, busy, timeout_pulse, frame_err}, 32'd0);
    chk({tag, "_dst"}, {12'd0, dst0_vsync, dst0_href, dst0_gray, dst1_vsync, dst1_href, dst1_gray}, 32'd0);
  endtask

  task automatic idle_srcs();
    src0_vsync = 1'b0; src0_href = 1'b0; src0_gray = 8'd0;
    src1_vsync = 1'b0; src1_href = 1'b0; src1_gray = 8'd0;
  endtask

  // Drive the owner; the other source gets random href/gray that must be ignored
  task automatic set_src(input int s, input logic vs, input logic hr, input logic [7:0] g);
    logic [7:0] jg;
    logic jh;
    jg = 8'($urandom);
    jh = 1'($urandom);
    if (s == 0) begin
      src0_vsync = vs; src0_href = hr; src0_gray = g;
      src1_vsync = 1'b0; src1_href = jh; src1_gray = jg;
    end else begin
      src1_vsync = vs; src1_href = hr; src1_gray = g;
      src0_vsync = 1'b0; src0_href = jh; src0_gray = jg;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0_req = 1'b0; src1_req = 1'b0;
    idle_srcs();
    pipeq.delete(); dstq.delete(); gntq.delete();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    prio_m = 1'b0;
  endtask

  task automatic wait_gnt(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc = i + 1;
      if (src0_gnt) begin who = 0; break; end
      if (src1_gnt) begin who = 1; break; end
    end
    chk("gnt_within_bound", {31'd0, who < 0}, 32'd0);
    if (who < 0) who = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic drive_frame(input int s, input int lines, input int short_line,
                             input int abort_line, input bit keep_req, output bit aborted);
    logic [7:0] g;
    int npx;
    bit exp_err;
    aborted = 1'b0;
    exp_err = (lines != VD) || (short_line >= 0 && short_line < lines);
    set_src(s, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    if (!keep_req) begin
      if (s == 0) src0_req = 1'b0; else src1_req = 1'b0;
    end
    set_src(s, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    for (int l = 0; l < lines; l++) begin
      npx = (l == short_line) ? HD - 1 : HD;
      for (int p = 0; p < npx; p++) begin
        if (l == abort_line && p == 3) begin
          #2;
          rst_n = 1'b0;
          aborted = 1'b1;
          return;
        end
        g = 8'($urandom_range(1, 255));
        set_src(s, 1'b1, 1'b1, g);
        pipeq.push_back({1'(s), g});
        dstq.push_back({1'(s), g});
        @(negedge clk);
      end
      repeat (3) begin
        set_src(s, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
      end
    end
    set_src(s, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    chk("frame_err_pulse", {31'd0, frame_err}, {31'd0, exp_err});
    chk("gnt_drop_at_vsync_fall", {31'd0, (s == 0) ? src0_gnt : src1_gnt}, 32'd0);
    idle_srcs();
  endtask

  task automatic run_frame(input int s, input int lines, input int short_line, input bit keep_req);
    int es;
    bit ab;
    bit exp_err;
    es = err_cnt;
    exp_err = (lines != VD) || (short_line >= 0 && short_line < lines);
    drive_frame(s, lines, short_line, -1, keep_req, ab);
    wait_idle("busy_low_after_drain");
    chk("frame_err_count", err_cnt - es, {31'd0, exp_err});
    prio_m = (s == 0);
  endtask

  initial begin
    int who, cyc, rem0, rem1, ts;
    bit ab;
    rst_n = 1'b0;
    src0_req = 1'b0; src1_req = 1'b0;
    idle_srcs();

    // Single source, clean 8x4 frame
    do_reset();
    gntq.push_back(1'(pick(1'b1, 1'b0)));
    src0_req = 1'b1;
    wait_gnt(who, cyc);
    chk("t1_gnt_latency", cyc, 32'd1);
    chk("t1_gnt_who", who, 32'd0);
    run_frame(who, VD, -1, 1'b0);
    chk("t1_dstq_drained", dstq.size(), 32'd0);

    // Both sources, three frames each, alternate from reset
    do_reset();
    rem0 = 3; rem1 = 3;
    gntq.push_back(1'(pick(1'b1, 1'b1)));
    src0_req = 1'b1; src1_req = 1'b1;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) gntq.push_back(1'(pick(rem0 > 0, rem1 > 0)));
      wait_gnt(who, cyc);
      if (who == 0) begin run_frame(0, VD, -1, rem0 > 1); rem0--; end
      else begin run_frame(1, VD, -1, rem1 > 1); rem1--; end
    end

    // Withdrawal in GRANT leaves the pointer alone
    gntq.push_back(1'(pick(1'b1, 1'b0)));
    src0_req = 1'b1;
    wait_gnt(who, cyc);
    repeat (3) @(negedge clk);
    src0_req = 1'b0;
    @(negedge clk);
    chk("withdraw_gnt_low", {31'd0, src0_gnt}, 32'd0);
    chk("withdraw_busy_low", {31'd0, busy}, 32'd0);
    gntq.push_back(1'(pick(1'b1, 1'b1)));
    src0_req = 1'b1; src1_req = 1'b1;
    wait_gnt(who, cyc);
    chk("withdraw_then_tie", who, 32'd0);
    run_frame(who, VD, -1, 1'b0);

    // src1 granted but never starts: timeout, pending src0 granted next
    gntq.push_back(1'(pick(1'b0, 1'b1)));
    wait_gnt(who, cyc);
    chk("tmo_grant_src1", who, 32'd1);
    repeat (5) @(negedge clk);
    src0_req = 1'b1;
    ts = tmo_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (timeout_pulse) break;
    end
    chk("tmo_pulse_seen", {31'd0, timeout_pulse}, 32'd1);
    chk("tmo_gnt_dropped", {31'd0, src1_gnt}, 32'd0);
    prio_m = 1'b0;
    src1_req = 1'b0;
    gntq.push_back(1'(pick(1'b1, 1'b0)));
    wait_gnt(who, cyc);
    chk("tmo_next_latency", cyc, 32'd1);
    chk("tmo_pulse_count", tmo_cnt - ts, 32'd1);

    // Geometry errors: three lines, then one 7-pixel line
    run_frame(0, 3, -1, 1'b1);
    gntq.push_back(1'(pick(1'b1, 1'b0)));
    wait_gnt(who, cyc);
    run_frame(0, VD, 1, 1'b0);

    // Reset in the middle of line 2, then src1 alone
    gntq.push_back(1'(pick(1'b1, 1'b0)));
    src0_req = 1'b1;
    wait_gnt(who, cyc);
    drive_frame(0, VD, -1, 2, 1'b0, ab);
    #1;
    check_all_zero("midframe_reset");
    src0_req = 1'b0;
    idle_srcs();
    pipeq.delete(); dstq.delete(); gntq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prio_m = 1'b0;
    repeat (5) @(negedge clk);
    gntq.push_back(1'(pick(1'b0, 1'b1)));
    src1_req = 1'b1;
    wait_gnt(who, cyc);
    chk("post_reset_gnt_who", who, 32'd1);
    chk("post_reset_latency", cyc, 32'd1);
    run_frame(1, VD, -1, 1'b0);

    repeat (5) @(negedge clk);
    chk("final_pipeq_empty", pipeq.size(), 32'd0);
    chk("final_dstq_empty", dstq.size(), 32'd0);
    chk("final_gntq_empty", gntq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sharpen_frame_arbiter.md
Name: sharpen_frame_arbiter

Overview:
- Frame-granular arbiter that shares one Laplacian sharpen pipeline between two video sources (src0, src1) with vsync/href/gray timing.
- Grants the pipeline for one whole frame at a time, using round-robin between the sources.
- Forwards the granted source into the pipeline. Routes the pipeline's processed output back to the source that owns the frame.
- Sits between two camera/preprocess paths and the single shared sharpen instance.

Parameters:
- IMG_HDISP, 640, active pixels per line (frame-size check).
- IMG_VDISP, 480, active lines per frame (frame-size check).
- TIMEOUT, 2000000, cycle limit for the GRANT wait and for the DRAIN wait.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- src0_req, src1_req  in  1  source has a frame pending
- src0_gnt, src1_gnt  out  1  source may start its frame (raise vsync)
- src0_vsync/href, src1_vsync/href  in  1  source timing
- src0_gray, src1_gray  in  8  source pixel
- pipe_vsync, pipe_href  out  1  to shared pipeline
- pipe_gray  out  8  to shared pipeline
- pipe_post_vsync, pipe_post_href  in  1  from shared pipeline
- pipe_post_gray  in  8  from shared pipeline
- dst0_vsync/href, dst1_vsync/href  out  1  demuxed processed timing
- dst0_gray, dst1_gray  out  8  demuxed processed pixel
- owner  out  1  current/last owner index
- busy  out  1  state != IDLE
- timeout_pulse  out  1  one-cycle pulse on a GRANT or DRAIN timeout
- frame_err  out  1  one-cycle pulse on a frame-size mismatch

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk. Reset state is IDLE. All outputs are 0. Priority pointer is set to src0 (owner=0).
- IDLE: requesters are sampled every cycle.
  - One req: grant it.
  - Both reqs: grant the source not equal to last completed owner; after reset, src0 wins.
  - The selected source becomes owner and the state moves to GRANT. gnt rises the cycle after req is seen (1-cycle latency).
- GRANT:
  - gnt held high.
  - Owner vsync rise -> INFLIGHT.
  - Owner req drops before vsync -> IDLE next cycle; gnt drops; priority unchanged.
  - TIMEOUT cycles without vsync -> IDLE, timeout_pulse, priority advanced.
- INFLIGHT:
  - gnt held high.
  - On owner vsync fall: gnt drops and the state moves to DRAIN.
  - The falling vsync sample is forwarded on that same cycle.
- Forwarding: in GRANT and INFLIGHT, pipe_* are registered copies of the owner's src_* (1-cycle latency). In all other states and for the non-owner, pipe_* = 0. The non-owner's inputs are ignored entirely.
- Frame check in INFLIGHT:
  - Count owner href-high cycles per line and href falling edges per frame.
  - Any line length != IMG_HDISP, or line count != IMG_VDISP at vsync fall -> frame_err pulse one cycle after the vsync fall.
  - The frame is still forwarded normally.
- DRAIN:
  - seen_rise flag records a pipe_post_vsync rise. It is also set during INFLIGHT.
  - On pipe_post_vsync fall with seen_rise=1 -> IDLE; last owner recorded for round-robin.
  - TIMEOUT cycles in DRAIN -> IDLE with timeout_pulse.
- Demux: in INFLIGHT and DRAIN, dst{owner}_* are registered copies of pipe_post_* (1-cycle latency). The other dst is 0. In IDLE and GRANT, both dst are 0.
- A new req arriving during INFLIGHT/DRAIN waits; it is never preempted.
- gnt is one-hot or zero; never both high.
- Async reset mid-frame: immediate return to IDLE with all outputs 0. Counters and seen_rise are cleared.

Test Plan:
- IMG_HDISP=8, IMG_VDISP=4, TIMEOUT=64, pipeline modelled as a 20-cycle delay.
  - src0_req alone, 8x4 frame -> src0_gnt high 1 cycle after req.
  - pipe_* equal src0 delayed by 1.
  - dst0 receives all 32 pixels delayed by 21 cycles; dst1 stays 0.
  - busy low after pipe_post_vsync falls.
- src0_req and src1_req asserted together from reset, each sending 3 frames -> grant order is 0,1,0,1,0,1.
  - Never both gnt high; non-owner pipe contribution is 0.
- src1 granted, but its vsync is never raised -> after 64 cycles timeout_pulse=1, gnt drops, state IDLE.
  - A pending src0_req is granted next.
- src0 sends a frame with 3 lines, or with one line of 7 pixels -> frame_err pulse 1 cycle after vsync fall.
  - Pipeline drain still completes and the arbiter returns to IDLE.
- src0_req withdrawn in GRANT before vsync -> gnt low next cycle; priority unchanged.
  - Both reqs next -> src1 wins only if src0 previously completed a frame.
- rst_n asserted mid-INFLIGHT (line 2) -> all outputs 0 immediately.
  - After release with src1_req only -> src1 granted cleanly; no frame_err.
